// File: rtl/span_fragment_generator_pkg.sv
// Shared raster types: span record, traversal states and the lane-offset helper.
package raster_pkg;

    localparam int SPAN_W       = 32;
    localparam int SPAN_COORD_W = 16;
    localparam int SPAN_LANES   = 4;

    typedef struct packed {
        logic [SPAN_COORD_W-1:0]      x;
        logic [SPAN_COORD_W-1:0]      y;
        logic [SPAN_LANES-1:0]        mask;
        logic [SPAN_LANES*SPAN_W-1:0] w0;
        logic [SPAN_LANES*SPAN_W-1:0] w1;
        logic [SPAN_LANES*SPAN_W-1:0] w2;
    } span_t;

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, ROW} span_state_t;

    // i*dy modulo 2^W built from shifted copies of dy; i covers 0..16.
    function automatic logic [SPAN_W-1:0] lane_offset(input logic [4:0] i,
                                                      input logic [SPAN_W-1:0] dy);
        logic [SPAN_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < 5; b++) begin
            if (i[b]) acc = acc + (dy << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/span_fragment_generator_if.sv
// Triangle-setup inputs and span-output handshake of the span fragment generator.
interface span_fragment_generator_if #(
    parameter int W       = 32,
    parameter int COORD_W = 16,
    parameter int LANES   = 4
);
    logic                     start;
    logic [COORD_W-1:0]       xmin, xmax, ymin, ymax;
    logic [W-1:0]             l0_dx, l1_dx, l2_dx;
    logic [W-1:0]             l0_dy, l1_dy, l2_dy;
    logic [W-1:0]             w0_00, w1_00, w2_00;
    logic [2:0]               edge_tl;
    logic                     pop_span;
    logic                     span_val;
    logic [COORD_W-1:0]       span_x, span_y;
    logic [LANES-1:0]         span_mask;
    logic [LANES*W-1:0]       span_w0, span_w1, span_w2;
    logic                     busy;
    logic                     done;

    modport master (
        output start, xmin, xmax, ymin, ymax, l0_dx, l1_dx, l2_dx,
               l0_dy, l1_dy, l2_dy, w0_00, w1_00, w2_00, edge_tl, pop_span,
        input  span_val, span_x, span_y, span_mask, span_w0, span_w1, span_w2,
               busy, done
    );

    modport slave (
        input  start, xmin, xmax, ymin, ymax, l0_dx, l1_dx, l2_dx,
               l0_dy, l1_dy, l2_dy, w0_00, w1_00, w2_00, edge_tl, pop_span,
        output span_val, span_x, span_y, span_mask, span_w0, span_w1, span_w2,
               busy, done
    );
endinterface

// File: rtl/span_fragment_generator_fifo.sv
// Synchronous span FIFO, 2^LG_DEPTH entries; head read combinationally.
// Push while full and pop while empty are ignored; pointers carry one wrap bit.
module span_fifo
    import raster_pkg::*;
#(
    parameter int LG_DEPTH = 3
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  span_t din_i,
    input  logic  pop_i,
    output span_t dout_o,
    output logic  full_o,
    output logic  empty_o
);

    span_t               mem_q [2**LG_DEPTH];
    logic [LG_DEPTH:0]   head_q, tail_q;

    assign empty_o = (head_q == tail_q);
    assign full_o  = (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]) &&
                     (head_q[LG_DEPTH] != tail_q[LG_DEPTH]);
    assign dout_o  = mem_q[head_q[LG_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (push_i && !full_o) tail_q <= tail_q + 1'b1;
            if (pop_i && !empty_o) head_q <= head_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[tail_q[LG_DEPTH-1:0]] <= din_i;
    end

endmodule

// File: rtl/span_fragment_generator.sv
// Walks a triangle bbox in LANES-wide spans, pushing covered spans to a FIFO (SCAN cycle t -> span_val at t+1).
// SCAN stalls while the FIFO is full; FRAG_TOP_LEFT_EN enables the top-left rule for zero edge values.
module span_fragment_generator
    import raster_pkg::*;
#(
    parameter int W          = SPAN_W,
    parameter int COORD_W    = SPAN_COORD_W,
    parameter int LANES      = SPAN_LANES,
    parameter int LG_FIFO_SZ = 3
) (
    input  logic clk,
    input  logic rst,
    span_fragment_generator_if.slave bus
);

    span_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xmin_q, xmax_q, ymax_q;
    logic [W-1:0]       w_q [3];
    logic [W-1:0]       w_d [3];
    logic [W-1:0]       rb_q [3];
    logic [W-1:0]       rb_d [3];
    logic [W-1:0]       dx_q [3];
    logic [W-1:0]       dy_q [3];
    logic [W-1:0]       step_q [3];
    logic [W-1:0]       off_q [3][LANES];
    logic [W-1:0]       lane_w [3][LANES];
    logic [W-1:0]       w00_in [3];
    logic [W-1:0]       dx_in [3];
    logic [W-1:0]       dy_in [3];
    logic [LANES-1:0]   mask;
    logic [2:0]         tl_eff;
    logic               done_q, done_d;
    logic               push, load, row_end, box_empty;
    logic               fifo_full, fifo_empty;
    span_t              push_dat, head;

    assign w00_in[0] = bus.w0_00;
    assign w00_in[1] = bus.w1_00;
    assign w00_in[2] = bus.w2_00;
    assign dx_in[0]  = bus.l0_dx;
    assign dx_in[1]  = bus.l1_dx;
    assign dx_in[2]  = bus.l2_dx;
    assign dy_in[0]  = bus.l0_dy;
    assign dy_in[1]  = bus.l1_dy;
    assign dy_in[2]  = bus.l2_dy;

    assign box_empty = (bus.xmin > bus.xmax) || (bus.ymin > bus.ymax);
    assign load      = (state_q == IDLE) && bus.start && !box_empty;
    assign row_end   = ({1'b0, x_q} + (COORD_W+1)'(LANES)) > {1'b0, xmax_q};

`ifdef FRAG_TOP_LEFT_EN
    logic [2:0] tl_q;
    always_ff @(posedge clk) begin
        if (load) tl_q <= bus.edge_tl;
    end
    assign tl_eff = tl_q;
`else
    // With every edge flagged top-left, zero is always inside.
    logic unused_tl;
    assign unused_tl = ^bus.edge_tl;
    assign tl_eff    = 3'b111;
`endif

    function automatic logic edge_in(input logic [W-1:0] v, input logic tl);
        return !v[W-1] && ((v != '0) || tl);
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < LANES; i++) lane_w[k][i] = w_q[k] + off_q[k][i];
        end
    end

    always_comb begin
        mask     = '0;
        push_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = (({1'b0, x_q} + (COORD_W+1)'(i)) <= {1'b0, xmax_q}) &&
                      edge_in(lane_w[0][i], tl_eff[0]) &&
                      edge_in(lane_w[1][i], tl_eff[1]) &&
                      edge_in(lane_w[2][i], tl_eff[2]);
            push_dat.w0[i*W +: W] = lane_w[0][i];
            push_dat.w1[i*W +: W] = lane_w[1][i];
            push_dat.w2[i*W +: W] = lane_w[2][i];
        end
        push_dat.x    = x_q;
        push_dat.y    = y_q;
        push_dat.mask = mask;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        rb_d    = rb_q;
        done_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (box_empty) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SETUP;
                        x_d     = bus.xmin;
                        y_d     = bus.ymin;
                        w_d     = w00_in;
                        rb_d    = w00_in;
                    end
                end
            end
            SETUP: state_d = SCAN;
            SCAN: begin
                // A full FIFO freezes the walk; the span is re-evaluated next cycle.
                if (!fifo_full) begin
                    push = |mask;
                    if (row_end) begin
                        if (y_q == ymax_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ROW;
                        end
                    end else begin
                        x_d = x_q + COORD_W'(LANES);
                        for (int k = 0; k < 3; k++) w_d[k] = w_q[k] + step_q[k];
                    end
                end
            end
            ROW: begin
                state_d = SCAN;
                y_d     = y_q + COORD_W'(1);
                x_d     = xmin_q;
                for (int k = 0; k < 3; k++) begin
                    rb_d[k] = rb_q[k] + dx_q[k];
                    w_d[k]  = rb_q[k] + dx_q[k];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q  <= x_d;
        y_q  <= y_d;
        w_q  <= w_d;
        rb_q <= rb_d;
        if (load) begin
            xmin_q <= bus.xmin;
            xmax_q <= bus.xmax;
            ymax_q <= bus.ymax;
            dx_q   <= dx_in;
            dy_q   <= dy_in;
        end
        if (state_q == SETUP) begin
            for (int k = 0; k < 3; k++) begin
                step_q[k] <= lane_offset(5'(LANES), dy_q[k]);
                for (int i = 0; i < LANES; i++) off_q[k][i] <= lane_offset(5'(i), dy_q[k]);
            end
        end
    end

    span_fifo #(.LG_DEPTH(LG_FIFO_SZ)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_dat),
        .pop_i   (bus.pop_span),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.span_val  = !fifo_empty;
    assign bus.span_x    = head.x;
    assign bus.span_y    = head.y;
    assign bus.span_mask = head.mask;
    assign bus.span_w0   = head.w0;
    assign bus.span_w1   = head.w1;
    assign bus.span_w2   = head.w2;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_span_fragment_generator.sv
// Scoreboarded random/directed bench for span_fragment_generator against a direct per-pixel edge-function model.
module tb_span_fragment_generator;
    import raster_pkg::*;

    localparam int W  = 32;
    localparam int CW = 16;
    localparam int L  = 4;
    localparam int LG = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    span_fragment_generator_if #(.W(W), .COORD_W(CW), .LANES(L)) bus ();

    span_fragment_generator #(.W(W), .COORD_W(CW), .LANES(L), .LG_FIFO_SZ(LG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          val_seen = 0;
    int          pop_mode = 2;
    span_t       exp_q[$];

    int          t_xmin, t_xmax, t_ymin, t_ymax;
    logic [31:0] t_w00 [3];
    logic [31:0] t_dx [3];
    logic [31:0] t_dy [3];
    logic [2:0]  t_tl;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic bit ins(input logic [31:0] v, input bit tl);
`ifdef FRAG_TOP_LEFT_EN
        return !v[31] && (v != 0 || tl);
`else
        return !v[31] && (tl || !tl);
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.pop_span = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (pop_mode)
                0:       bus.pop_span = 1'b1;
                1:       bus.pop_span = 1'($urandom_range(0, 1));
                default: bus.pop_span = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT hands over a span.
    initial forever begin
        span_t got, e;
        @(negedge clk);
        if (rst !== 1'b1) begin
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 512'(bus.busy), 512'(0));
            end
            if (bus.span_val === 1'b1) val_seen++;
            if (bus.span_val === 1'b1 && bus.pop_span === 1'b1) begin
                got.x = bus.span_x;    got.y = bus.span_y;   got.mask = bus.span_mask;
                got.w0 = bus.span_w0;  got.w1 = bus.span_w1; got.w2 = bus.span_w2;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_span got=%0h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("span", 512'(got), 512'(e));
                end
            end
        end
    end

    task automatic drive_inputs();
        bus.xmin = 16'(t_xmin); bus.xmax = 16'(t_xmax);
        bus.ymin = 16'(t_ymin); bus.ymax = 16'(t_ymax);
        bus.w0_00 = t_w00[0]; bus.w1_00 = t_w00[1]; bus.w2_00 = t_w00[2];
        bus.l0_dx = t_dx[0];  bus.l1_dx = t_dx[1];  bus.l2_dx = t_dx[2];
        bus.l0_dy = t_dy[0];  bus.l1_dy = t_dy[1];  bus.l2_dy = t_dy[2];
        bus.edge_tl = t_tl;
    endtask

    task automatic run_tri(input int mode, input bit stall, input bit timed);
        int n_exp, n_cyc, t0, d0, v0, nsp, rows;
        span_t e;
        logic [31:0] v [3];
        n_exp = 0;
        n_cyc = 0;
        if (t_xmin <= t_xmax && t_ymin <= t_ymax) begin
            nsp   = (t_xmax - t_xmin) / L + 1;
            rows  = t_ymax - t_ymin + 1;
            n_cyc = nsp * rows + rows;
            for (int y = t_ymin; y <= t_ymax; y++) begin
                for (int xo = 0; t_xmin + xo <= t_xmax; xo += L) begin
                    e = '0;
                    e.x = 16'(t_xmin + xo);
                    e.y = 16'(y);
                    for (int i = 0; i < L; i++) begin
                        for (int k = 0; k < 3; k++)
                            v[k] = t_w00[k] + 32'(y - t_ymin) * t_dx[k] + 32'(xo + i) * t_dy[k];
                        e.mask[i] = (t_xmin + xo + i <= t_xmax) && ins(v[0], t_tl[0]) &&
                                    ins(v[1], t_tl[1]) && ins(v[2], t_tl[2]);
                        e.w0[i*W +: W] = v[0];
                        e.w1[i*W +: W] = v[1];
                        e.w2[i*W +: W] = v[2];
                    end
                    if (e.mask != '0) begin
                        exp_q.push_back(e);
                        n_exp++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        pop_mode = stall ? 2 : mode;
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0 = cyc;
        d0 = done_cnt;
        v0 = val_seen;
        // Garbage inputs plus a second start while busy must not disturb the walk.
        if (bus.busy) begin
            bus.xmin = 16'($urandom); bus.xmax = 16'($urandom); bus.ymax = 16'($urandom);
            bus.w0_00 = $urandom; bus.l0_dx = $urandom; bus.l1_dy = $urandom;
            bus.edge_tl = 3'($urandom);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        if (stall) begin
            repeat (40) @(posedge clk);
            #1;
            check("stall_busy", 512'(bus.busy), 512'(1));
            check("stall_no_done", 512'(done_cnt - d0), 512'(0));
            check("stall_span_val", 512'(bus.span_val), 512'(1));
            pop_mode = mode;
        end
        for (int c = 0; c < 4000 && done_cnt == d0; c++) @(posedge clk);
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=no_done exp=done");
        end else if (timed) begin
            check("done_time", 512'(done_cyc - t0), 512'(n_cyc));
        end
        for (int c = 0; c < 4000 && exp_q.size() != 0; c++) @(posedge clk);
        check("drain_left", 512'(exp_q.size()), 512'(0));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 512'(done_cnt - d0), 512'(1));
        check("busy_idle", 512'(bus.busy), 512'(0));
        check("val_idle", 512'(bus.span_val), 512'(0));
        if (n_exp == 0) check("no_span_val", 512'(val_seen - v0), 512'(0));
    endtask

    task automatic set_box(input int x0, input int x1, input int y0, input int y1);
        t_xmin = x0; t_xmax = x1; t_ymin = y0; t_ymax = y1;
    endtask

    task automatic set_edges(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [31:0] dx, input logic [31:0] dy);
        t_w00[0] = a; t_w00[1] = b; t_w00[2] = c;
        for (int k = 0; k < 3; k++) begin
            t_dx[k] = dx;
            t_dy[k] = dy;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=running exp=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        t_tl = 3'b000;
        set_box(0, 0, 0, 0);
        set_edges(0, 0, 0, 0, 0);
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_val", 512'(bus.span_val), 512'(0));
        check("reset_busy", 512'(bus.busy), 512'(0));
        check("reset_done", 512'(bus.done), 512'(0));
        rst = 1'b0;

        set_box(0, 7, 0, 1);      set_edges(1, 1, 1, 0, 0);  run_tri(0, 0, 1);
        set_box(0, 5, 0, 0);      set_edges(5, 5, 5, 1, 1);  run_tri(0, 0, 1);
        set_box(0, 7, 0, 0);      set_edges(-2, 3, 3, 0, 0);
        t_dy[0] = 1;              t_tl = 3'b000;             run_tri(0, 0, 1);
        t_tl = 3'b001;                                       run_tri(0, 0, 1);
        set_box(0, 7, 0, 2);      set_edges(-100, 1, 1, 0, 0); run_tri(0, 0, 1);
        set_box(0, 19, 3, 3);     set_edges(1, 1, 1, 0, 0);  run_tri(0, 1, 0);
        set_box(65530, 65535, 7, 8); set_edges(2, 2, 2, -1, 0); run_tri(1, 0, 0);
        set_box(9, 9, 4, 4);      set_edges(0, 0, 0, 0, 0);  run_tri(0, 0, 1);
        set_box(6, 5, 0, 3);                                 run_tri(0, 0, 1);
        set_box(0, 3, 5, 2);                                 run_tri(0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            t_xmin = $urandom_range(0, 20);
            t_xmax = t_xmin + $urandom_range(0, 18);
            t_ymin = $urandom_range(0, 5);
            t_ymax = t_ymin + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) t_xmin = t_xmax + 1;
            for (int k = 0; k < 3; k++) begin
                t_w00[k] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 120)) - 32'd60;
                t_dx[k]  = 32'($urandom_range(0, 40)) - 32'd20;
                t_dy[k]  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
            end
            t_tl = 3'($urandom);
            if ($urandom_range(0, 1) == 0) run_tri(0, 0, 1);
            else run_tri(1, 0, 0);
        end

        // Abort a walk with a full FIFO, then confirm a fresh triangle runs cleanly.
        set_box(0, 31, 0, 3);
        set_edges(1, 1, 1, 0, 0);
        @(posedge clk);
        #1;
        pop_mode = 2;
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_val", 512'(bus.span_val), 512'(1));
        check("pre_rst_busy", 512'(bus.busy), 512'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_val", 512'(bus.span_val), 512'(0));
        check("abort_busy", 512'(bus.busy), 512'(0));
        check("abort_done", 512'(bus.done), 512'(0));
        exp_q.delete();
        set_box(2, 12, 1, 2);
        set_edges(4, 7, 1, 32'hFFFF_FFFE, 1);
        run_tri(0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/span_fragment_generator.md
Name: span_fragment_generator

Overview:
- Parametrised successor to the scalar fragment generator.
- Walks a triangle's inclusive bounding box in horizontal spans of LANES pixels per cycle, using integer/fixed-point edge functions with single-cycle adders (no FP adder pipeline).
- Emits one span record per cycle (base x, y, per-lane coverage mask, per-lane w0..w2) into an internal FIFO drained by the shader/ROP stage through a valid/pop handshake.
- Sits between triangle setup and per-fragment interpolation.

Parameters:
- W, 32, signed edge-function width (two's complement fixed point).
- COORD_W, 16, unsigned pixel-coordinate width.
- LANES, 4, pixels evaluated per span (power of two, 1..16).
- LG_FIFO_SZ, 3, log2 of output FIFO depth in spans.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a triangle; sampled only in IDLE
- xmin, xmax, ymin, ymax  in  COORD_W each  inclusive bounding box
- l0_dx, l1_dx, l2_dx  in  W each  per-row edge increments
- l0_dy, l1_dy, l2_dy  in  W each  per-column edge increments
- w0_00, w1_00, w2_00  in  W each  edge values at (xmin, ymin)
- edge_tl  in  3  top/left flag per edge (used only with the optional feature)
- pop_span  in  1  consumer takes the head span
- span_val  out  1  FIFO non-empty
- span_x, span_y  out  COORD_W each  head span base coordinates
- span_mask  out  LANES  head span coverage; bit i = pixel span_x+i
- span_w0, span_w1, span_w2  out  LANES*W each  head span per-lane edge values, lane i at [i*W +: W]
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of traversal

Behaviour:
- Reset is synchronous and active-high: rst, clock clk. On reset: state=IDLE, FIFO head=tail=0, span_val=0, busy=0, done=0. Storage contents are don't-care.
- Reset mid-traversal aborts immediately and discards FIFO contents.
- States: IDLE, SETUP, SCAN, ROW.
- IDLE, start=1: latch all inputs; x=xmin, y=ymin; row base and current w = w*_00; go to SETUP. If xmin>xmax or ymin>ymax, go directly to IDLE instead, pulse done next cycle, push nothing.
- SETUP (1 cycle): compute lane offsets off_k[i] = i*lk_dy and span step LANES*lk_dy, using shift/add only, modulo 2^W. Go to SCAN.
- SCAN, each cycle the FIFO is not full:
  - lane i value = w_k + off_k[i].
  - lane_in_box = (x+i <= xmax).
  - covered = lane_in_box && all three values >= 0 (sign bit clear; zero counts as inside).
  - Push {x, y, mask, values} only if the mask is non-zero; empty spans are skipped and still take one cycle.
  - If x+LANES > xmax (computed at COORD_W+1 bits): if y==ymax, go to IDLE with done=1 the same cycle; else go to ROW.
  - Otherwise x += LANES and w_k += LANES*lk_dy.
- SCAN with FIFO full: stall, all state held. A pop in the same cycle does not unblock the push; the push retries next cycle.
- ROW (1 cycle): y += 1; x = xmin; rowbase_k += lk_dx; w_k = new rowbase_k. Go to SCAN.
- Per-span latency: SCAN cycle t → span_val=1 at t+1 (FIFO registered, read combinational from head).
- Throughput: 1 span/cycle, plus 1 bubble per row, plus 1 SETUP cycle.
- FIFO: pointers have LG_FIFO_SZ+1 bits.
  - empty = (head == tail).
  - full = low bits equal and MSB differs.
  - Wrap-around is natural pointer overflow.
  - pop_span while empty is ignored.
  - Simultaneous push+pop when non-full updates both pointers.
- Arithmetic wraps modulo 2^W; no saturation.
- start while busy is ignored. done does not wait for the FIFO to drain.

Optional Feature:
- FRAG_TOP_LEFT_EN defined: a lane value of exactly 0 on edge k counts as covered only if edge_tl[k]=1 (D3D top-left fill rule). Negative values are always outside.
- FRAG_TOP_LEFT_EN undefined: zero is always inside, and edge_tl is ignored (port retained, unused).

Decomposition:
- Shared package raster_pkg holds:
  - span_t struct parametrised via localparams: x, y, mask, w0..w2 arrays.
  - span_state_t enum {IDLE, SETUP, SCAN, ROW}.
  - Helper function lane_offset(i, dy) using shift/add.
- One natural sub-module: span_fifo, a parametrised synchronous FIFO of span_t with push/pop/full/empty. The generator holds the FSM and datapath.

Test Plan:
- LANES=4, box x 0..7, y 0..1, w*_00=1, all dx=dy=0 → 4 spans, masks 4'hF, x=0,4,0,4, y=0,0,1,1; done pulses the cycle after the last push; busy deasserts.
- Box x 0..5, y 0..0, all positive → spans x=0 mask 4'hF, x=4 mask 4'h3 (lanes beyond xmax cleared).
- w0_00=-2, l0_dy=1, others positive, box x 0..7 → span x=0 mask 4'hC (lane values -2,-1,0,1), span x=4 mask 4'hF. With FRAG_TOP_LEFT_EN and edge_tl[0]=0 → first mask 4'h8.
- Fully outside triangle (w0_00=-100, dy=0) over 3 rows → no pushes, span_val stays 0, done pulses once.
- LG_FIFO_SZ=1, pop_span held low, 5 covered spans → exactly 2 stored, generator stalls in SCAN; releasing pop drains all 5 in order with correct x/y.
- Assert rst mid-SCAN with 2 spans queued → next cycle span_val=0, busy=0, done=0; a fresh start then runs normally.
